// File: rtl/uart_rx_core_pkg.sv
// Shared types and defaults for the 16x-oversampling UART receiver.
// The transmitter uses the same default divider and oversample rate.
package uart_rx_core_pkg;

   localparam int DEFAULT_CLOCKS_PER_TICK = 54;
   localparam int DEFAULT_OVERSAMPLE      = 16;
   localparam int DEFAULT_DATA_BITS       = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } rx_state_e;

   // Counter width for a 0..n-1 counter, never narrower than one bit
   function automatic int cnt_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_rx_tick_generator.sv
// Oversample tick divider: one-cycle tick every CLOCKS_PER_TICK clocks.
// A synchronous clear restarts the phase so ticks line up with a start edge.
module uart_rx_tick_generator
   import uart_rx_core_pkg::*;
#(
   parameter int CLOCKS_PER_TICK = DEFAULT_CLOCKS_PER_TICK
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int            CW   = cnt_width(CLOCKS_PER_TICK);
   localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_TICK - 1);

   logic [CW-1:0] count_r;

   // Free-running divider with restart on clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_r <= '0;
      end else if (clear) begin
         count_r <= '0;
      end else if (count_r == LAST) begin
         count_r <= '0;
      end else begin
         count_r <= count_r + CW'(1);
      end
   end

   assign tick = (count_r == LAST);

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with 16x oversampling, one-byte output register with
// valid/read handshake, sticky overrun and framing-error pulse.
module uart_rx_core
   import uart_rx_core_pkg::*;
#(
   parameter int CLOCKS_PER_TICK = DEFAULT_CLOCKS_PER_TICK,
   parameter int OVERSAMPLE      = DEFAULT_OVERSAMPLE,
   parameter int DATA_BITS       = DEFAULT_DATA_BITS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   input  logic                 data_read,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 overrun,
   output logic                 framing_error,
   output logic                 busy
);

   localparam int            TW        = cnt_width(OVERSAMPLE);
   localparam int            BW        = cnt_width(DATA_BITS);
   localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

   logic                 sync1_r, sync2_r, rx_prev_r;
   logic                 rx_sync_s, start_s, tick_s, stop_centre_s, new_byte_s;
   rx_state_e            state_r;
   logic [TW-1:0]        tick_count_r;
   logic [BW-1:0]        bit_count_r;
   logic [DATA_BITS-1:0] shift_r;
   logic [DATA_BITS-1:0] data_out_r;
   logic                 data_valid_r, overrun_r, framing_error_r, busy_r;

   assign rx_sync_s     = sync2_r;
   // Falling edge only, so a line held low after a break cannot retrigger
   assign start_s       = (state_r == ST_IDLE) && rx_prev_r && !rx_sync_s;
   assign stop_centre_s = (state_r == ST_STOP) && tick_s && (tick_count_r == BIT_LAST);
   assign new_byte_s    = stop_centre_s && rx_sync_s;

   uart_rx_tick_generator #(
      .CLOCKS_PER_TICK(CLOCKS_PER_TICK)
   ) u_tick (
      .clk  (clk),
      .reset(reset),
      .clear(start_s),
      .tick (tick_s)
   );

   // Two-flop synchronizer plus one delayed copy for edge detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_r   <= 1'b1;
         sync2_r   <= 1'b1;
         rx_prev_r <= 1'b1;
      end else begin
         sync1_r   <= rx;
         sync2_r   <= sync1_r;
         rx_prev_r <= sync2_r;
      end
   end

   // Frame FSM: start validation, data bit shifting, stop bit centre
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r      <= ST_IDLE;
         tick_count_r <= '0;
         bit_count_r  <= '0;
         shift_r      <= '0;
         busy_r       <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start_s) begin
                  state_r      <= ST_START;
                  tick_count_r <= '0;
                  bit_count_r  <= '0;
                  busy_r       <= 1'b1;
               end
            end
            ST_START: begin
               if (tick_s) begin
                  if (tick_count_r == HALF_LAST) begin
                     tick_count_r <= '0;
                     if (!rx_sync_s) begin
                        state_r <= ST_DATA;
                     end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                     end
                  end else begin
                     tick_count_r <= tick_count_r + TW'(1);
                  end
               end
            end
            ST_DATA: begin
               if (tick_s) begin
                  if (tick_count_r == BIT_LAST) begin
                     tick_count_r <= '0;
                     shift_r      <= {rx_sync_s, shift_r[DATA_BITS-1:1]};
                     if (bit_count_r == LAST_BIT) begin
                        bit_count_r <= '0;
                        state_r     <= ST_STOP;
                     end else begin
                        bit_count_r <= bit_count_r + BW'(1);
                     end
                  end else begin
                     tick_count_r <= tick_count_r + TW'(1);
                  end
               end
            end
            ST_STOP: begin
               if (tick_s) begin
                  if (tick_count_r == BIT_LAST) begin
                     tick_count_r <= '0;
                     state_r      <= ST_IDLE;
                     busy_r       <= 1'b0;
                  end else begin
                     tick_count_r <= tick_count_r + TW'(1);
                  end
               end
            end
            default: begin
               state_r      <= ST_IDLE;
               tick_count_r <= '0;
               bit_count_r  <= '0;
               busy_r       <= 1'b0;
            end
         endcase
      end
   end

   // Output register, handshake and error flags
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_out_r      <= '0;
         data_valid_r    <= 1'b0;
         overrun_r       <= 1'b0;
         framing_error_r <= 1'b0;
      end else begin
         framing_error_r <= stop_centre_s && !rx_sync_s;
         if (new_byte_s) begin
            data_out_r   <= shift_r;
            data_valid_r <= 1'b1;
            // A read in the load cycle consumes the old byte, so no overrun
            if (data_valid_r && !data_read) begin
               overrun_r <= 1'b1;
            end else if (data_read) begin
               overrun_r <= 1'b0;
            end
         end else if (data_read && data_valid_r) begin
            data_valid_r <= 1'b0;
            overrun_r    <= 1'b0;
         end
      end
   end

   assign data_out      = data_out_r;
   assign data_valid    = data_valid_r;
   assign overrun       = overrun_r;
   assign framing_error = framing_error_r;
   assign busy          = busy_r;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: hand-driven 8N1 frames on rx with a fast
// divider, checking outputs against hand-computed values.
module tb_uart_rx_core;

   localparam int CPT = 4;
   localparam int OS  = 16;
   localparam int BIT = CPT * OS;

   logic       clk       = 1'b0;
   logic       reset     = 1'b0;
   logic       rx        = 1'b1;
   logic       data_read = 1'b0;
   logic [7:0] data_out;
   logic       data_valid, overrun, framing_error, busy;

   int total    = 0;
   int passed   = 0;
   int fe_count = 0;
   int fe0      = 0;

   always #5 clk = ~clk;

   // Count framing-error pulses seen by the bench
   always @(posedge clk) begin
      if (framing_error === 1'b1) fe_count <= fe_count + 1;
   end

   uart_rx_core #(
      .CLOCKS_PER_TICK(CPT),
      .OVERSAMPLE     (OS),
      .DATA_BITS      (8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .rx           (rx),
      .data_read    (data_read),
      .data_out     (data_out),
      .data_valid   (data_valid),
      .overrun      (overrun),
      .framing_error(framing_error),
      .busy         (busy)
   );

   task automatic drive_bit(input logic v, input int n);
      rx = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      drive_bit(1'b0, BIT);
      for (int i = 0; i < 8; i++) drive_bit(b[i], BIT);
      drive_bit(stop, BIT);
      rx = 1'b1;
   endtask

   task automatic do_read();
      data_read = 1'b1;
      @(negedge clk);
      data_read = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      total++; if (data_out !== 8'h00) $display("FAIL rst_data_out got %h want 00", data_out); else passed++;
      total++; if (data_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", data_valid); else passed++;
      total++; if (overrun !== 1'b0) $display("FAIL rst_overrun got %b want 0", overrun); else passed++;
      total++; if (framing_error !== 1'b0) $display("FAIL rst_fe got %b want 0", framing_error); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else passed++;
   endtask

   task automatic test_single_byte();
      fe0 = fe_count;
      send_frame(8'h0A, 1'b1);
      repeat (8) @(negedge clk);
      total++; if (data_out !== 8'h0A) $display("FAIL t1_data_out got %h want 0a", data_out); else passed++;
      total++; if (data_valid !== 1'b1) $display("FAIL t1_valid got %b want 1", data_valid); else passed++;
      total++; if (overrun !== 1'b0) $display("FAIL t1_overrun got %b want 0", overrun); else passed++;
      total++; if (fe_count - fe0 !== 0) $display("FAIL t1_fe_pulses got %0d want 0", fe_count - fe0); else passed++;
      do_read();
      total++; if (data_valid !== 1'b0) $display("FAIL t1_read_valid got %b want 0", data_valid); else passed++;
   endtask

   task automatic test_glitch();
      fe0 = fe_count;
      rx = 1'b0;
      repeat (4 * CPT) @(negedge clk);
      total++; if (busy !== 1'b1) $display("FAIL t2_busy_low got %b want 1", busy); else passed++;
      rx = 1'b1;
      repeat (40) @(negedge clk);
      total++; if (busy !== 1'b0) $display("FAIL t2_busy_end got %b want 0", busy); else passed++;
      total++; if (data_valid !== 1'b0) $display("FAIL t2_valid got %b want 0", data_valid); else passed++;
      total++; if (fe_count - fe0 !== 0) $display("FAIL t2_fe_pulses got %0d want 0", fe_count - fe0); else passed++;
   endtask

   task automatic test_framing();
      fe0 = fe_count;
      send_frame(8'h55, 1'b0);
      repeat (16) @(negedge clk);
      total++; if (fe_count - fe0 !== 1) $display("FAIL t3_fe_pulses got %0d want 1", fe_count - fe0); else passed++;
      total++; if (data_valid !== 1'b0) $display("FAIL t3_valid_bad got %b want 0", data_valid); else passed++;
      send_frame(8'h33, 1'b1);
      repeat (8) @(negedge clk);
      total++; if (data_out !== 8'h33) $display("FAIL t3_data_out got %h want 33", data_out); else passed++;
      total++; if (data_valid !== 1'b1) $display("FAIL t3_valid_good got %b want 1", data_valid); else passed++;
      do_read();
   endtask

   task automatic test_overrun();
      send_frame(8'h0D, 1'b1);
      send_frame(8'h0E, 1'b1);
      repeat (8) @(negedge clk);
      total++; if (data_out !== 8'h0E) $display("FAIL t4_data_out got %h want 0e", data_out); else passed++;
      total++; if (overrun !== 1'b1) $display("FAIL t4_overrun got %b want 1", overrun); else passed++;
      do_read();
      total++; if (data_valid !== 1'b0) $display("FAIL t4_read_valid got %b want 0", data_valid); else passed++;
      total++; if (overrun !== 1'b0) $display("FAIL t4_read_overrun got %b want 0", overrun); else passed++;
   endtask

   // Falling edge at negedge 0 is seen in IDLE at posedge 3; the stop-centre
   // tick is consumed 608 clocks later, so data_read is driven at negedge 610.
   task automatic test_read_collision();
      send_frame(8'h0D, 1'b1);
      fork
         send_frame(8'h0E, 1'b1);
         begin
            repeat (610) @(negedge clk);
            data_read = 1'b1;
            @(negedge clk);
            data_read = 1'b0;
         end
      join
      repeat (8) @(negedge clk);
      total++; if (data_out !== 8'h0E) $display("FAIL t5_data_out got %h want 0e", data_out); else passed++;
      total++; if (data_valid !== 1'b1) $display("FAIL t5_valid got %b want 1", data_valid); else passed++;
      total++; if (overrun !== 1'b0) $display("FAIL t5_overrun got %b want 0", overrun); else passed++;
   endtask

   task automatic test_reset_midframe();
      drive_bit(1'b0, BIT);
      for (int i = 0; i < 3; i++) drive_bit(1'b1, BIT);
      drive_bit(1'b1, BIT / 2);
      reset = 1'b0;
      #1;
      total++; if (data_out !== 8'h00) $display("FAIL t6_rst_data_out got %h want 00", data_out); else passed++;
      total++; if (data_valid !== 1'b0) $display("FAIL t6_rst_valid got %b want 0", data_valid); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL t6_rst_busy got %b want 0", busy); else passed++;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      repeat (BIT) @(negedge clk);
      fe0 = fe_count;
      send_frame(8'hA5, 1'b1);
      repeat (8) @(negedge clk);
      total++; if (data_out !== 8'hA5) $display("FAIL t6_data_out got %h want a5", data_out); else passed++;
      total++; if (data_valid !== 1'b1) $display("FAIL t6_valid got %b want 1", data_valid); else passed++;
      total++; if (overrun !== 1'b0) $display("FAIL t6_overrun got %b want 0", overrun); else passed++;
      total++; if (fe_count - fe0 !== 0) $display("FAIL t6_fe_pulses got %0d want 0", fe_count - fe0); else passed++;
      do_read();
   endtask

   task automatic test_break();
      fe0 = fe_count;
      rx = 1'b0;
      repeat (12 * BIT) @(negedge clk);
      total++; if (fe_count - fe0 !== 1) $display("FAIL t7_fe_pulses got %0d want 1", fe_count - fe0); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL t7_busy got %b want 0", busy); else passed++;
      total++; if (data_valid !== 1'b0) $display("FAIL t7_valid got %b want 0", data_valid); else passed++;
      rx = 1'b1;
      repeat (16) @(negedge clk);
      send_frame(8'h3C, 1'b1);
      repeat (8) @(negedge clk);
      total++; if (data_out !== 8'h3C) $display("FAIL t7_data_out got %h want 3c", data_out); else passed++;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      test_reset();
      reset = 1'b1;
      repeat (4 * BIT) @(negedge clk);
      test_single_byte();
      test_glitch();
      test_framing();
      test_overrun();
      test_read_collision();
      test_reset_midframe();
      test_break();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
